// File: rtl/mul_pkg.sv
// Shared multiplier definitions: RISC-V M-extension multiply op encoding and
// the operand/product widths used by the Booth front end, the compressor tree
// and the final carry-propagate stage.
package mul_pkg;

  localparam int MUL_XLEN   = 32;
  localparam int MUL_PROD_W = 2 * MUL_XLEN;

  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_t;

endpackage

// File: rtl/mul_cpa_stage_adder32.sv
// Plain ripple-free behavioural adder: a + b + cin with carry-out.
// Used for both the low-half and the high-half product words.
module adder32 #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // Widen by one bit so the carry-out falls out of the same add.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/mul_cpa_stage.sv
// Final carry-propagate stage of the Wallace-tree multiplier. Resolves the
// carry-save pair into the 64-bit product over two pipeline stages (low word
// first, high word second, carry handed across the stage register), picks the
// low or high word by op, and hands it off under valid/ready with flush.
module mul_cpa_stage
  import mul_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*XLEN-1:0]   in_sum,
  input  logic [2*XLEN-1:0]   in_carry,
  input  logic [1:0]          in_op,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_result,
  output logic [TAG_W-1:0]    out_tag
);

  logic             s1_valid, s2_valid;
  logic             s1_adv, s2_adv;
  logic             s1_load, s2_load;

  logic [XLEN-1:0]  lo_sum, hi_sum;
  logic             lo_cout;
  logic             unused_hi_cout;   // bit-64 carry of the product is dropped

  logic [XLEN-1:0]  s1_lo, s1_hi_sum, s1_hi_carry;
  logic             s1_c32;
  mul_op_t          s1_op;
  logic [TAG_W-1:0] s1_tag;

  // A stage may take new data when it is empty or its occupant leaves now.
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign s1_load  = in_valid && s1_adv;
  assign s2_load  = s1_valid && s2_adv;

  assign out_valid = s2_valid;

  adder32 #(.W(XLEN)) u_add_lo (
    .a    (in_sum[XLEN-1:0]),
    .b    (in_carry[XLEN-1:0]),
    .cin  (1'b0),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  adder32 #(.W(XLEN)) u_add_hi (
    .a    (s1_hi_sum),
    .b    (s1_hi_carry),
    .cin  (s1_c32),
    .sum  (hi_sum),
    .cout (unused_hi_cout)
  );

  // Occupancy bits; flush wins over any transfer happening the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_adv) s1_valid <= in_valid;
      if (s2_adv) s2_valid <= s1_valid;
    end
  end

  // S1 data: low-half sum plus its carry, high halves parked for S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_lo       <= '0;
      s1_c32      <= 1'b0;
      s1_hi_sum   <= '0;
      s1_hi_carry <= '0;
      s1_op       <= MUL;
      s1_tag      <= '0;
    end else if (s1_load) begin
      s1_lo       <= lo_sum;
      s1_c32      <= lo_cout;
      s1_hi_sum   <= in_sum[2*XLEN-1:XLEN];
      s1_hi_carry <= in_carry[2*XLEN-1:XLEN];
      s1_op       <= mul_op_t'(in_op);
      s1_tag      <= in_tag;
    end
  end

  // S2 data: finish the high half and keep only the word the op asks for.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_result <= '0;
      out_tag    <= '0;
    end else if (s2_load) begin
      out_result <= (s1_op == MUL) ? s1_lo : hi_sum;
      out_tag    <= s1_tag;
    end
  end

endmodule

// File: tb/tb_mul_cpa_stage.sv
// Bench for mul_cpa_stage: directed vector table, streaming, backpressure,
// flush and async-reset sequences, with a scoreboard queue of expected words.
module tb_mul_cpa_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_sum = '0;
  logic [63:0] in_carry = '0;
  logic [1:0]  in_op = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_tag;

  mul_cpa_stage #(.XLEN(32), .TAG_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sum     (in_sum),
    .in_carry   (in_carry),
    .in_op      (in_op),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] sum;
    logic [63:0] carry;
    logic [1:0]  op;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   run = 0;
  int   max_run = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [63:0] s, input logic [63:0] c,
                                        input logic [1:0] op);
    logic [63:0] p;
    p = s + c;
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  // Output side: pop and compare on every handshake, track valid run length,
  // and forget in-flight entries killed by flush.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (out_valid) run++; else run = 0;
      if (run > max_run) max_run = run;
      if (out_valid && out_ready && !flush) begin
        if (sb.size() == 0) check("unexpected_out", 64'd1, 64'd0);
        else begin
          e = sb.pop_front();
          check("result", {32'd0, out_result}, {32'd0, e.res});
          check("tag", {59'd0, out_tag}, {59'd0, e.tag});
        end
      end
      if (flush) sb.delete();
    end
  end

  // Offer one input until accepted; record its expected result on acceptance.
  task automatic send(input logic [63:0] s, input logic [63:0] c, input logic [1:0] op,
                      input logic [4:0] tag, input logic [31:0] exp);
    int  n;
    bit  done;
    exp_t e;
    n = 0;
    done = 0;
    in_valid = 1'b1; in_sum = s; in_carry = c; in_op = op; in_tag = tag;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        e.res = exp; e.tag = tag;
        if (!flush) sb.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
      n++;
      if (!done && n > 50) begin
        check("in_ready_timeout", 64'd0, 64'd1);
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", sb.size(), 64'd0);
  endtask

  initial begin
    vec_t        tbl[6];
    logic [63:0] bp_s[5], bp_c[5], rs, rc;
    int          acc;
    exp_t        e;

    #200000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[6];
    logic [63:0] bp_s[5], bp_c[5], rs, rc;
    logic [1:0]  rop;
    int          acc;
    exp_t        e;

    tbl[0] = '{64'h00000000_FFFFFFFF, 64'h00000000_00000001, 2'd1, 5'd3,  32'h00000001};
    tbl[1] = '{64'h00000000_FFFFFFFF, 64'h00000000_00000001, 2'd0, 5'd4,  32'h00000000};
    tbl[2] = '{64'hFFFFFFFF_FFFFFFFF, 64'h00000000_00000001, 2'd3, 5'd21, 32'h00000000};
    tbl[3] = '{64'h12345678_9ABCDEF0, 64'h11111111_11111111, 2'd2, 5'd7,  32'h23456789};
    tbl[4] = '{64'h12345678_9ABCDEF0, 64'h11111111_11111111, 2'd0, 5'd8,  32'hABCDF001};
    tbl[5] = '{64'h7FFFFFFF_80000000, 64'h00000000_80000000, 2'd1, 5'd31, 32'h80000000};

    // Reset state
    #12;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_result", {32'd0, out_result}, 64'd0);
    check("rst_out_tag", {59'd0, out_tag}, 64'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;

    // Directed vectors; first one also checks the two-cycle latency
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].sum, tbl[i].carry, tbl[i].op, tbl[i].tag, tbl[i].exp);
      if (i == 0) begin
        check("lat_not_yet", {63'd0, out_valid}, 64'd0);
        @(posedge clk); #1;
        check("lat_valid", {63'd0, out_valid}, 64'd1);
      end
      drain();
    end

    // Streaming: 8 back-to-back, no bubbles, in-order tags 1..8
    max_run = 0;
    for (int i = 1; i <= 8; i++) begin
      rs = {$urandom(), $urandom()};
      rc = {$urandom(), $urandom()};
      rop = 2'($urandom_range(0, 3));
      send(rs, rc, rop, 5'(i), model(rs, rc, rop));
    end
    drain();
    check("stream_run", max_run, 64'd8);

    // Backpressure: continuous input, consumer stalled for 5 cycles
    for (int i = 0; i < 5; i++) begin
      bp_s[i] = {$urandom(), $urandom()};
      bp_c[i] = {$urandom(), $urandom()};
    end
    out_ready = 1'b0;
    acc = 0;
    in_valid = 1'b1; in_sum = bp_s[0]; in_carry = bp_c[0]; in_op = 2'd1; in_tag = 5'd10;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (cyc >= 2 && sb.size() != 0) begin
        check("bp_stable_result", {32'd0, out_result}, {32'd0, sb[0].res});
        check("bp_stable_tag", {59'd0, out_tag}, {59'd0, sb[0].tag});
      end
      if (in_ready) begin
        e.res = model(bp_s[acc], bp_c[acc], 2'd1); e.tag = 5'(10 + acc);
        sb.push_back(e);
        acc++;
      end
      @(posedge clk); #1;
      if (acc < 5) begin
        in_sum = bp_s[acc]; in_carry = bp_c[acc]; in_tag = 5'(10 + acc);
      end
    end
    check("bp_accepts", acc, 64'd2);
    check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    check("bp_out_valid", {63'd0, out_valid}, 64'd1);
    out_ready = 1'b1;
    for (int i = 2; i < 5; i++)
      send(bp_s[i], bp_c[i], 2'd1, 5'(10 + i), model(bp_s[i], bp_c[i], 2'd1));
    drain();

    // Flush with both stages full; input in the flush cycle is dropped
    out_ready = 1'b0;
    send(64'h1, 64'h2, 2'd0, 5'd20, 32'h3);
    send(64'h5, 64'h6, 2'd0, 5'd21, 32'hB);
    flush = 1'b1;
    in_valid = 1'b1; in_sum = 64'h7; in_carry = 64'h8; in_op = 2'd0; in_tag = 5'd22;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("flush_dropped", {63'd0, out_valid}, 64'd0);
    send(64'hAAAAAAAA_FFFFFFF0, 64'h11111111_00000020, 2'd3, 5'd23, 32'hBBBBBBBC);
    check("flush_lat_not_yet", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    check("flush_lat_valid", {63'd0, out_valid}, 64'd1);
    drain();

    // Async reset between edges, mid-stream
    send(64'h00000001_00000001, 64'h1, 2'd1, 5'd24, 32'h1);
    send(64'h00000002_00000001, 64'h1, 2'd1, 5'd25, 32'h2);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_out_result", {32'd0, out_result}, 64'd0);
    sb.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    #1;
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    check("arst_no_stale", {63'd0, out_valid}, 64'd0);
    send(64'hFFFFFFFF_FFFFFFFF, 64'hFFFFFFFF_FFFFFFFF, 2'd2, 5'd26, 32'hFFFFFFFF);
    drain();

    check("final_queue_empty", sb.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
